// File: rtl/xbar_crdt_rtn_gen.sv
// xbar_crdt_rtn_gen: advertises, tracks and returns ingress credits for the three ISU->xbar request channels.
// Define MPC_CRDT_RTN_COALESCE_EN to batch credit returns by threshold/timeout instead of returning immediately.
module xbar_crdt_rtn_gen #(
   parameter int NumCh   = 3,
   parameter int ChDepth = 8,
   parameter int CrdtW   = 4,
   parameter int CoalThr = 4,
   parameter int CoalTmo = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         d_req_valid,
   input  logic [NumCh-1:0]             d_req_channel_1hot_id,
   input  logic [NumCh-1:0]             slot_free,
   output logic [NumCh-1:0][CrdtW-1:0]  u_xbar_crdt_rtn,
   output logic                         init_done,
   output logic [NumCh-1:0]             crdt_err
);

   localparam int OccW = $clog2(ChDepth + 1);

   if (CoalThr > ChDepth || CoalThr < 1 || CoalTmo < 2 || (1 << CrdtW) <= ChDepth) begin : g_cfg_err
      $error("xbar_crdt_rtn_gen: inconsistent credit parameters");
   end

   typedef enum logic [1:0] {S_RST, S_INIT, S_RUN} state_t;

   state_t                       r_state, w_state_nxt;
   logic [NumCh-1:0][OccW-1:0]   r_occ, w_occ_nxt;
   logic [NumCh-1:0][CrdtW-1:0]  r_rtn, w_rtn_nxt;
   logic [NumCh-1:0]             r_err, w_err_nxt;
   logic                         r_init_done;
   logic [NumCh-1:0]             w_req, w_vfree, w_ovf;
   logic                         w_onehot;

`ifdef MPC_CRDT_RTN_COALESCE_EN
   localparam int TmrW = $clog2(CoalTmo);
   logic [NumCh-1:0][CrdtW-1:0]  r_pend, w_pend_nxt, w_sum;
   logic [NumCh-1:0][TmrW-1:0]   r_tmr, w_tmr_nxt;
   logic [NumCh-1:0]             w_flush;
`endif

   always_comb begin
      w_state_nxt = r_state;
      if (r_state == S_RST) w_state_nxt = S_INIT;
      else w_state_nxt = S_RUN;
   end

   assign w_onehot = $onehot(d_req_channel_1hot_id);

   always_comb begin
      w_occ_nxt = r_occ;
      w_rtn_nxt = '0;
      w_err_nxt = r_err;
      w_req     = '0;
      w_vfree   = '0;
      w_ovf     = '0;
`ifdef MPC_CRDT_RTN_COALESCE_EN
      w_pend_nxt = r_pend;
      w_tmr_nxt  = r_tmr;
      w_sum      = '0;
      w_flush    = '0;
`endif
      if (r_state != S_RUN) begin
         // Traffic before the initial advertisement is a protocol violation and is dropped.
         w_err_nxt = r_err | slot_free | (d_req_valid ? d_req_channel_1hot_id : '0);
         w_rtn_nxt = (r_state == S_INIT) ? {NumCh{CrdtW'(ChDepth)}} : '0;
      end else begin
         if (d_req_valid && !w_onehot) w_err_nxt = w_err_nxt | d_req_channel_1hot_id;
         for (int i = 0; i < NumCh; i++) begin
            w_req[i]   = d_req_valid && w_onehot && d_req_channel_1hot_id[i];
            w_vfree[i] = slot_free[i] && (r_occ[i] != '0);
            w_ovf[i]   = w_req[i] && (r_occ[i] == OccW'(ChDepth)) && !w_vfree[i];
            if ((slot_free[i] && r_occ[i] == '0) || w_ovf[i]) w_err_nxt[i] = 1'b1;
            w_occ_nxt[i] = r_occ[i] + OccW'(w_req[i] && !w_ovf[i]) - OccW'(w_vfree[i]);
`ifdef MPC_CRDT_RTN_COALESCE_EN
            w_sum[i]      = r_pend[i] + CrdtW'(w_vfree[i]);
            w_flush[i]    = (w_sum[i] >= CrdtW'(CoalThr)) ||
                            ((r_tmr[i] == TmrW'(CoalTmo - 1)) && (r_pend[i] != '0));
            w_rtn_nxt[i]  = w_flush[i] ? w_sum[i] : '0;
            w_pend_nxt[i] = w_flush[i] ? '0 : w_sum[i];
            w_tmr_nxt[i]  = (w_flush[i] || r_pend[i] == '0) ? '0 : r_tmr[i] + TmrW'(1);
`else
            w_rtn_nxt[i] = CrdtW'(w_vfree[i]);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_RST;
         r_occ       <= '0;
         r_rtn       <= '0;
         r_err       <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_occ       <= w_occ_nxt;
         r_rtn       <= w_rtn_nxt;
         r_err       <= w_err_nxt;
         r_init_done <= (r_state == S_RUN);
      end
   end

`ifdef MPC_CRDT_RTN_COALESCE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend <= '0;
         r_tmr  <= '0;
      end else begin
         r_pend <= w_pend_nxt;
         r_tmr  <= w_tmr_nxt;
      end
   end
`endif

   assign u_xbar_crdt_rtn = r_rtn;
   assign init_done       = r_init_done;
   assign crdt_err        = r_err;

endmodule
